priority_decoder_collector: RTL
===============================

Name: priority_decoder_collector

Overview:
- Inverse partner of the priority encoder: accepts a stream of encoded bit indices and expands each one into a one-hot word.
- The one-hot word is forwarded on a registered valid/ready output stream with skid buffering.
- Each accepted index is also accumulated into a sticky pending bitmap. Software or downstream logic clears that bitmap per bit.
- Used to rebuild request/interrupt bitmaps from index-encoded event traffic. Reports range errors and duplicate events.

Parameters:
- WIDTH, 4, number of decoded bits (≥1).
- ENC_WIDTH, (WIDTH>2 ? $clog2(WIDTH) : 1), width of encoded index; may be overridden larger than the default.
- CNT_WIDTH, 8, width of saturating duplicate-event counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- input_encoded  input  ENC_WIDTH  index to decode.
- input_valid  input  1  index valid.
- input_ready  output  1  block can accept; registered.
- output_unencoded  output  WIDTH  one-hot decoded word.
- output_valid  output  1  output word valid.
- output_ready  input  1  downstream accepts.
- pending  output  WIDTH  sticky bitmap of decoded events.
- clear_mask  input  WIDTH  per-bit clear of pending; level, applied each cycle it is high.
- err_clear  input  1  clears error_range and dup_count.
- error_range  output  1  sticky: an index ≥ WIDTH was accepted.
- dup_count  output  CNT_WIDTH  saturating count of accepts whose bit was already pending.

Behaviour:
- Reset (rst_n low, async): output_valid=0, output_unencoded=0, skid empty, input_ready=1, pending=0, error_range=0, dup_count=0. This applies mid-transfer too; in-flight words are discarded. Outputs hold reset values until the first rising edge after rst_n deasserts.
- Accept: input_valid && input_ready on a rising edge.
- Output path is a two-register skid (main + skid):
  - Main empty, or main consumed this cycle (output_valid && output_ready): the accepted one-hot word loads main.
  - Otherwise the word loads skid.
  - When main is consumed and skid is full, skid moves to main.
- input_ready = !skid_full, registered. Full throughput when output_ready is held high. Latency from accept to output_valid is 1 cycle.
- output_unencoded/output_valid are stable while output_valid && !output_ready.
- Out of range (input_encoded ≥ WIDTH, possible when WIDTH is not a power of two or ENC_WIDTH is overridden): the index is consumed and dropped. Nothing is forwarded, pending is unchanged, error_range is set.
- Pending update each cycle: pending_next = (pending & ~clear_mask) | set_vec. set_vec is the one-hot of an accepted in-range index. Set wins over a same-cycle clear of the same bit.
- Duplicate: an accepted in-range index i with pending[i]=1 and clear_mask[i]=0 that cycle increments dup_count. The counter saturates at 2^CNT_WIDTH-1 and never wraps.
- Pending and dup tracking occur at accept time, independent of output backpressure.
- err_clear: on that edge error_range and dup_count are cleared first, then same-cycle events are applied. A range error or duplicate in the same cycle leaves error_range=1 or dup_count=1 respectively.
- No combinational path from input_valid or output_ready to input_ready.

Test Plan:
1. WIDTH=5, output_ready=1. Send indices 0,1,4 on back-to-back cycles -> output_unencoded 00001, 00010, 10000 on consecutive cycles, each 1 cycle after accept. pending=10011. input_ready stays 1.
2. WIDTH=5. Hold output_ready=0 and send indices 2,3 -> main=00100, skid=01000, input_ready=0 on the next cycle. Raise output_ready -> 00100 then 01000 delivered in order, input_ready returns to 1, no word lost or duplicated.
3. WIDTH=5. Send index 6 -> no output_valid pulse, pending unchanged, error_range=1. Pulse err_clear -> error_range=0. Pulse err_clear again in the same cycle as sending index 7 -> error_range=1.
4. WIDTH=5, CNT_WIDTH=2. Send index 1 five times without clearing -> dup_count 0,1,2,3,3 (saturates at 3). Send index 1 with clear_mask=00010 in the same cycle -> pending[1]=1 and dup_count unchanged.
5. Drive clear_mask=11111 -> pending=0 next edge. Then send index 2 while clear_mask=00100 -> pending=00100 (set wins).
6. With main and skid full, assert rst_n=0 asynchronously between edges -> output_valid, pending, error_range and dup_count drop to 0 immediately, input_ready=1. After release the first accepted index appears on output 1 cycle later.

Source files
------------

// File: rtl/priority_decoder_collector.sv
`default_nettype none
// ============================================================================
// Module      : priority_decoder_collector
// Description : Expands encoded bit indices into one-hot words on a skid-buffered
//               valid/ready stream and collects them into a sticky pending bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_decoder_collector #(
    parameter int WIDTH     = 4,
    parameter int ENC_WIDTH = (WIDTH > 2) ? $clog2(WIDTH) : 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ENC_WIDTH-1:0] input_encoded,
    input  logic                 input_valid,
    output logic                 input_ready,
    output logic [WIDTH-1:0]     output_unencoded,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [WIDTH-1:0]     pending,
    input  logic [WIDTH-1:0]     clear_mask,
    input  logic                 err_clear,
    output logic                 error_range,
    output logic [CNT_WIDTH-1:0] dup_count
);

    localparam logic [ENC_WIDTH:0]   c_width_ext = (ENC_WIDTH+1)'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = {CNT_WIDTH{1'b1}};

    logic                 r_main_valid;
    logic [WIDTH-1:0]     r_main_data;
    logic                 r_skid_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic                 r_in_ready;
    logic [WIDTH-1:0]     r_pending;
    logic                 r_error_range;
    logic [CNT_WIDTH-1:0] r_dup_count;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_fwd;
    logic                 w_consume;
    logic [WIDTH-1:0]     w_onehot;
    logic                 w_dup;
    logic                 w_skid_valid_next;
    logic [CNT_WIDTH-1:0] w_dup_base;

    always_comb begin
        w_accept   = input_valid && r_in_ready;
        w_in_range = ({1'b0, input_encoded} < c_width_ext);
        w_fwd      = w_accept && w_in_range;
        w_consume  = r_main_valid && output_ready;
        w_onehot   = w_fwd ? (WIDTH'(1) << input_encoded) : '0;
        // A bit being cleared this cycle is not counted as a repeat.
        w_dup      = |(r_pending & ~clear_mask & w_onehot);
        w_dup_base = err_clear ? '0 : r_dup_count;
        // Accepts only happen while the skid is empty, so it fills only
        // when main is holding and not draining.
        if (r_skid_valid) begin
            w_skid_valid_next = !w_consume;
        end else begin
            w_skid_valid_next = r_main_valid && !w_consume && w_fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_in_ready   <= !w_skid_valid_next;
            r_skid_valid <= w_skid_valid_next;
            if (!r_main_valid || w_consume) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                end else begin
                    r_main_valid <= w_fwd;
                    r_main_data  <= w_onehot;
                end
            end else if (w_fwd) begin
                r_skid_data <= w_onehot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_error_range <= 1'b0;
            r_dup_count   <= '0;
        end else begin
            r_pending     <= (r_pending & ~clear_mask) | w_onehot;
            r_error_range <= (r_error_range && !err_clear) || (w_accept && !w_in_range);
            if (w_dup && (w_dup_base != c_cnt_max)) begin
                r_dup_count <= w_dup_base + 1'b1;
            end else begin
                r_dup_count <= w_dup_base;
            end
        end
    end

    assign input_ready      = r_in_ready;
    assign output_valid     = r_main_valid;
    assign output_unencoded = r_main_data;
    assign pending          = r_pending;
    assign error_range      = r_error_range;
    assign dup_count        = r_dup_count;

endmodule
`default_nettype wire
